// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared opcode enumeration for the logic unit
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise operation mux
module logic_unit_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // select the bitwise function named by the opcode
    always_comb begin
        o_y = '0;
        case (op_e'(i_op))
            OP_AND:   o_y = i_a & i_b;
            OP_OR:    o_y = i_a | i_b;
            OP_XOR:   o_y = i_a ^ i_b;
            OP_NOR:   o_y = ~(i_a | i_b);
            OP_NAND:  o_y = ~(i_a & i_b);
            OP_XNOR:  o_y = ~(i_a ^ i_b);
            OP_NOTA:  o_y = ~i_a;
            OP_PASSA: o_y = i_a;
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - handshaked bitwise logic unit; LOGIC_UNIT_FLAGS_EN adds zero/parity flags
module logic_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic               chain,
    input  logic [WIDTH-1:0]   inputA,
    input  logic [WIDTH-1:0]   inputB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] outputC,
`ifdef LOGIC_UNIT_FLAGS_EN
    output logic [CNT_W-1:0]   op_count,
    output logic               zero_flag,
    output logic               parity_flag
`else
    output logic [CNT_W-1:0]   op_count
`endif
);

    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_c;
    logic [WIDTH-1:0]   r_chain;
    logic [CNT_W-1:0]   r_count;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_out_hs;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_y;

    // the single output register frees up in the same cycle it is drained
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_b        = chain ? r_chain : inputB;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op (op),
        .i_a  (inputA),
        .i_b  (w_b),
        .o_y  (w_y)
    );

    // output register, chain register and saturating handshake counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_chain     <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_c     <= {{WIDTH{1'b0}}, w_y};
                r_chain     <= w_y;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_hs && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic r_zero;
    logic r_parity;

    // flags track the result loaded into the output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_zero   <= (w_y == '0);
            r_parity <= ^w_y;
        end
    end

    assign zero_flag   = r_zero;
    assign parity_flag = r_parity;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign outputC   = r_out_c;
    assign op_count  = r_count;

endmodule
